l2_chan_interleaver: RTL and testbench

- Parametrised successor to the fixed single-bit DRAM/L2 channel select.
- Accepts one burst request (address, beat count, ID) at a time and splits it at interleave-block boundaries into per-channel sub-bursts.
- Sub-burst addresses are channel-local: the channel-select bits are compacted out.
- Pushes each sub-burst's channel and length into an order FIFO so the downstream response merger can reassemble data in order.
- Sits between the cluster AXI request path and the NumL2Channel L2/DRAM controllers.

---
 rtl/l2_chan_interleaver_pkg.sv | 32 +++
 rtl/l2_ord_fifo.sv | 65 ++++++
 rtl/l2_chan_interleaver.sv | 188 ++++++++++++++++++
 tb/tb_l2_chan_interleaver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_chan_interleaver_pkg.sv
// Shared definitions for the L2/DRAM channel interleaver: default channel
// map settings, order-entry layout and the splitter state encoding.
package l2_chan_interleaver_pkg;

  localparam int unsigned NumL2Channel      = 2;
  localparam int unsigned L2InterleaveBeats = 16;
  localparam int unsigned L2ChanSelBit      = 30;
  localparam int unsigned L2LenWidth        = 8;

  // Channel index width; a single channel still needs one (constant-zero) bit
  function automatic int unsigned chan_bits(input int unsigned num_chan);
    return (num_chan > 1) ? $clog2(num_chan) : 1;
  endfunction

  localparam int unsigned L2ChanBits = chan_bits(NumL2Channel);

  typedef enum logic {
    Contiguous  = 1'b0,
    Interleaved = 1'b1
  } l2_map_mode_e;

  typedef struct packed {
    logic [L2ChanBits-1:0] chan;
    logic [L2LenWidth-1:0] len;
  } l2_ord_t;

  typedef enum logic {
    Idle  = 1'b0,
    Split = 1'b1
  } l2_split_state_e;

endpackage

// File: rtl/l2_ord_fifo.sv
// Order FIFO holding {channel, length} of every issued sub-burst so the
// response merger can pull data back from the channels in issue order.
module l2_ord_fifo
  import l2_chan_interleaver_pkg::*;
#(
  parameter int unsigned Depth  = 8,
  parameter type         data_t = l2_ord_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  data_t wdata,
  input  logic  pop,
  output data_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  data_t            mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never makes room for a push into a full FIFO.
  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Entry storage; contents of free slots are don't-care so no reset here
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping, wrapping at Depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l2_chan_interleaver.sv
// Splits one burst request at a time into per-channel sub-bursts, either by
// interleave block (channel bits compacted out of the address) or by a single
// contiguous channel-select field, and logs each sub-burst in an order FIFO.
module l2_chan_interleaver
  import l2_chan_interleaver_pkg::*;
#(
  parameter int unsigned NumChannels     = NumL2Channel,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned BeatBytes       = 64,
  parameter int unsigned InterleaveBeats = L2InterleaveBeats,
  parameter int unsigned SelBit          = L2ChanSelBit,
  parameter int unsigned LenWidth        = L2LenWidth,
  parameter int unsigned IdWidth         = 6,
  parameter int unsigned OrdDepth        = 8,
  localparam int unsigned CB             = chan_bits(NumChannels)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_mode_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic [LenWidth-1:0]  in_len_i,
  input  logic [IdWidth-1:0]   in_id_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CB-1:0]        out_chan_o,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic [LenWidth-1:0]  out_len_o,
  output logic [IdWidth-1:0]   out_id_o,
  output logic                 out_last_o,
  output logic                 ord_valid_o,
  input  logic                 ord_ready_i,
  output logic [CB-1:0]        ord_chan_o,
  output logic [LenWidth-1:0]  ord_len_o,
  output logic                 busy_o
);

  localparam int unsigned BeatShift = $clog2(BeatBytes);
  localparam int unsigned Const     = $clog2(BeatBytes * InterleaveBeats);
  localparam int unsigned IlvBits   = $clog2(InterleaveBeats);
  localparam int unsigned RemW      = LenWidth + 1;
  localparam int unsigned BtbW      = IlvBits + 1;
  localparam int unsigned CmpW      = (RemW > BtbW) ? RemW : BtbW;
  localparam logic [AddrWidth-1:0] LowMask = AddrWidth'((64'd1 << Const) - 64'd1);
  localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(InterleaveBeats - 1);

  typedef struct packed {
    logic [CB-1:0]       chan;
    logic [LenWidth-1:0] len;
  } ord_t;

  l2_split_state_e      state_q;
  l2_split_state_e      state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [RemW-1:0]      rem_q;
  logic [IdWidth-1:0]   id_q;
  l2_map_mode_e         mode_q;

  logic [AddrWidth-1:0] blk_off;
  logic [BtbW-1:0]      btb;
  logic [RemW-1:0]      chunk;
  logic [CB-1:0]        sub_chan;
  logic [AddrWidth-1:0] sub_addr;
  logic [LenWidth-1:0]  sub_len;
  logic                 sub_last;

  logic                 accept;
  logic                 fire;
  logic                 ord_full;
  logic                 ord_empty;
  ord_t                 ord_wdata;
  ord_t                 ord_rdata;

  assign accept = in_valid_i && in_ready_o;
  assign fire   = out_valid_o && out_ready_i;

  // Size, channel and channel-local address of the sub-burst at addr_q
  always_comb begin
    blk_off  = (addr_q >> BeatShift) & OffMask;
    btb      = BtbW'(InterleaveBeats) - BtbW'(blk_off);
    chunk    = rem_q;
    sub_chan = '0;
    sub_addr = addr_q;
    if (mode_q == Interleaved) begin
      if (CmpW'(btb) < CmpW'(rem_q)) begin
        chunk = RemW'(btb);
      end
      if (NumChannels > 1) begin
        sub_chan = CB'(addr_q >> Const);
        sub_addr = ((addr_q >> (Const + CB)) << Const) | (addr_q & LowMask);
      end
    end else begin
      if (NumChannels > 1) begin
        sub_chan = CB'(addr_q >> SelBit);
      end
    end
    sub_len  = LenWidth'(chunk - 1'b1);
    sub_last = (chunk == rem_q);
  end

  // Burst context: captured on accept, advanced by one chunk on each fire
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
      id_q   <= '0;
      mode_q <= Contiguous;
    end else if (accept) begin
      addr_q <= in_addr_i;
      rem_q  <= RemW'(in_len_i) + 1'b1;
      id_q   <= in_id_i;
      mode_q <= l2_map_mode_e'(cfg_mode_i);
    end else if (fire) begin
      addr_q <= addr_q + (AddrWidth'(chunk) << BeatShift);
      rem_q  <= rem_q - chunk;
    end
  end

  // Splitter state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave Idle on accept, return after the last sub-burst fires
  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:    if (accept) state_d = Split;
      Split:   if (fire && sub_last) state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  // Outputs: request side ready only in Idle, sub-burst fields only in Split
  always_comb begin
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    out_valid_o = 1'b0;
    out_chan_o  = '0;
    out_addr_o  = '0;
    out_len_o   = '0;
    out_id_o    = '0;
    out_last_o  = 1'b0;
    case (state_q)
      Idle: begin
        in_ready_o = 1'b1;
      end
      Split: begin
        busy_o      = 1'b1;
        out_valid_o = !ord_full;
        out_chan_o  = sub_chan;
        out_addr_o  = sub_addr;
        out_len_o   = sub_len;
        out_id_o    = id_q;
        out_last_o  = sub_last;
      end
      default: begin
        in_ready_o = 1'b0;
      end
    endcase
  end

  assign ord_wdata.chan = sub_chan;
  assign ord_wdata.len  = sub_len;
  assign ord_valid_o    = !ord_empty;
  assign ord_chan_o     = ord_rdata.chan;
  assign ord_len_o      = ord_rdata.len;

  l2_ord_fifo #(
    .Depth  (OrdDepth),
    .data_t (ord_t)
  ) i_ord_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fire),
    .wdata (ord_wdata),
    .pop   (ord_valid_o && ord_ready_i),
    .rdata (ord_rdata),
    .full  (ord_full),
    .empty (ord_empty)
  );

endmodule

// File: tb/tb_l2_chan_interleaver.sv
// Randomised bench for l2_chan_interleaver with a burst-splitting reference
// model built from plain address arithmetic plus directed corner cases.
module tb_l2_chan_interleaver;

  localparam int unsigned NC  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned BB  = 64;
  localparam int unsigned IB  = 16;
  localparam int unsigned SB  = 30;
  localparam int unsigned LW  = 8;
  localparam int unsigned IDW = 6;
  localparam int unsigned OD  = 2;

  logic          clk_i;
  logic          rst_i;
  logic          cfg_mode_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [AW-1:0] in_addr_i;
  logic [LW-1:0] in_len_i;
  logic [IDW-1:0] in_id_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [0:0]    out_chan_o;
  logic [AW-1:0] out_addr_o;
  logic [LW-1:0] out_len_o;
  logic [IDW-1:0] out_id_o;
  logic          out_last_o;
  logic          ord_valid_o;
  logic          ord_ready_i;
  logic [0:0]    ord_chan_o;
  logic [LW-1:0] ord_len_o;
  logic          busy_o;

  l2_chan_interleaver #(
    .NumChannels     (NC),
    .AddrWidth       (AW),
    .BeatBytes       (BB),
    .InterleaveBeats (IB),
    .SelBit          (SB),
    .LenWidth        (LW),
    .IdWidth         (IDW),
    .OrdDepth        (OD)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_mode_i  (cfg_mode_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_addr_i   (in_addr_i),
    .in_len_i    (in_len_i),
    .in_id_i     (in_id_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_chan_o  (out_chan_o),
    .out_addr_o  (out_addr_o),
    .out_len_o   (out_len_o),
    .out_id_o    (out_id_o),
    .out_last_o  (out_last_o),
    .ord_valid_o (ord_valid_o),
    .ord_ready_i (ord_ready_i),
    .ord_chan_o  (ord_chan_o),
    .ord_len_o   (ord_len_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    int unsigned       chan;
    longint unsigned   addr;
    int unsigned       len;
    int unsigned       id;
    bit                last;
  } sub_t;

  typedef struct {
    int unsigned chan;
    int unsigned len;
  } ord_e;

  sub_t exp_q[$];
  ord_e ord_q[$];
  int   checks;
  int   errors;
  bit   accepted;

  // Free-running clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Watchdog so a stuck run still ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint unsigned got,
                             input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference split of one burst, straight from the channel-map arithmetic
  task automatic buildSubs(input longint unsigned addr, input int unsigned len,
                           input int unsigned id, input bit mode);
    longint unsigned a;
    int unsigned     rem;
    int unsigned     chunk;
    int unsigned     btb;
    sub_t            s;
    a   = addr;
    rem = len + 1;
    while (rem > 0) begin
      if (mode) begin
        btb    = IB - int'((a / BB) % IB);
        chunk  = (rem < btb) ? rem : btb;
        s.chan = int'((a / (BB * IB)) % NC);
        s.addr = (a / (BB * IB * NC)) * (BB * IB) + (a % (BB * IB));
      end else begin
        chunk  = rem;
        s.chan = int'((a >> SB) % NC);
        s.addr = a;
      end
      s.len  = chunk - 1;
      s.id   = id;
      s.last = (chunk == rem);
      exp_q.push_back(s);
      a   = (a + longint'(chunk) * BB) % (64'd1 << AW);
      rem = rem - chunk;
    end
  endtask

  // One clock: check outputs against the model, then advance the model
  task automatic tick();
    bit   exp_valid;
    ord_e oe;
    #1;
    accepted = 1'b0;
    if (rst_i) begin
      exp_q.delete();
      ord_q.delete();
    end else begin
      exp_valid = (exp_q.size() != 0) && (ord_q.size() < OD);
      checkOutput("busy", busy_o, exp_q.size() != 0);
      checkOutput("in_ready", in_ready_o, exp_q.size() == 0);
      checkOutput("out_valid", out_valid_o, exp_valid);
      checkOutput("ord_valid", ord_valid_o, ord_q.size() != 0);
      if (ord_q.size() != 0) begin
        checkOutput("ord_chan", ord_chan_o, ord_q[0].chan);
        checkOutput("ord_len", ord_len_o, ord_q[0].len);
      end
      if (exp_valid) begin
        checkOutput("out_chan", out_chan_o, exp_q[0].chan);
        checkOutput("out_addr", out_addr_o, exp_q[0].addr);
        checkOutput("out_len", out_len_o, exp_q[0].len);
        checkOutput("out_id", out_id_o, exp_q[0].id);
        checkOutput("out_last", out_last_o, exp_q[0].last);
      end
      if (ord_q.size() != 0 && ord_ready_i) begin
        void'(ord_q.pop_front());
      end
      if (exp_valid && out_ready_i) begin
        oe.chan = exp_q[0].chan;
        oe.len  = exp_q[0].len;
        ord_q.push_back(oe);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() == 0 && in_valid_i && !exp_valid) begin
        accepted = 1'b1;
        buildSubs(in_addr_i, in_len_i, in_id_i, cfg_mode_i);
      end
    end
    @(negedge clk_i);
  endtask

  // Drive one burst with the chosen ready patterns and run it to completion
  task automatic applyStimulus(input logic [AW-1:0] addr, input int unsigned len,
                               input int unsigned id, input bit mode,
                               input int out_pat, input int ord_pat);
    int  c;
    bit  done;
    c          = 0;
    done       = 1'b0;
    in_addr_i  = addr;
    in_len_i   = LW'(len);
    in_id_i    = IDW'(id);
    cfg_mode_i = mode;
    in_valid_i = 1'b1;
    while (!done && c < 600) begin
      case (out_pat)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = 1'($urandom_range(0, 1));
        default: out_ready_i = !(c >= 1 && c <= 5);
      endcase
      case (ord_pat)
        0:       ord_ready_i = 1'b1;
        1:       ord_ready_i = 1'($urandom_range(0, 1));
        default: ord_ready_i = (c >= 8);
      endcase
      tick();
      if (accepted) in_valid_i = 1'b0;
      done = !in_valid_i && exp_q.size() == 0;
      c++;
    end
    checkOutput("burst_done", done, 1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    ord_ready_i = 1'b1;
    c = 0;
    while (ord_q.size() != 0 && c < 20) begin
      tick();
      c++;
    end
    checkOutput("ord_drained", ord_q.size() == 0, 1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_i       = 1'b1;
    cfg_mode_i  = 1'b0;
    in_valid_i  = 1'b0;
    in_addr_i   = '0;
    in_len_i    = '0;
    in_id_i     = '0;
    out_ready_i = 1'b1;
    ord_ready_i = 1'b1;
    @(negedge clk_i);
    tick();
    tick();
    rst_i = 1'b0;
    checkOutput("rst_in_ready", in_ready_o, 1);
    checkOutput("rst_out_valid", out_valid_o, 0);
    checkOutput("rst_ord_valid", ord_valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_out_last", out_last_o, 0);
    checkOutput("rst_out_addr", out_addr_o, 0);
    checkOutput("rst_ord_len", ord_len_o, 0);

    $display("[TB] directed bursts");
    applyStimulus(32'h8000_0000, 15, 5, 1'b1, 0, 0);
    applyStimulus(32'h8000_0200, 31, 7, 1'b1, 0, 0);
    applyStimulus(32'hC000_0000, 255, 3, 1'b0, 0, 0);
    applyStimulus(32'h0000_0000, 63, 1, 1'b1, 0, 2);
    applyStimulus(32'h8000_0200, 31, 7, 1'b1, 2, 0);
    applyStimulus(32'hFFFF_FE00, 40, 2, 1'b1, 0, 1);

    $display("[TB] reset during split");
    cfg_mode_i  = 1'b1;
    in_addr_i   = 32'h8000_0200;
    in_len_i    = 8'd31;
    in_id_i     = 6'd9;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    ord_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("mid_rst_in_ready", in_ready_o, 1);
    checkOutput("mid_rst_out_valid", out_valid_o, 0);
    checkOutput("mid_rst_ord_valid", ord_valid_o, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    in_addr_i   = 32'h8000_0000;
    in_len_i    = 8'd15;
    in_id_i     = 6'd5;
    in_valid_i  = 1'b1;
    ord_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    checkOutput("post_rst_chan", out_chan_o, 0);
    checkOutput("post_rst_addr", out_addr_o, 32'h4000_0000);
    checkOutput("post_rst_len", out_len_o, 15);
    checkOutput("post_rst_id", out_id_o, 5);
    checkOutput("post_rst_last", out_last_o, 1);
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] random bursts");
    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom & 32'hFFFF_FFC0, $urandom_range(0, 255),
                    $urandom_range(0, 63), 1'($urandom_range(0, 1)), 1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
